// File: rtl/fetch_stallmem.sv
// -----------------------------------------------------------------------------
// fetch_stallmem
//
// Instruction-fetch stage in front of decode. It owns the PC and fetches
// 16-bit instructions from an instruction memory that can take several cycles
// to answer. Each fetched instruction is held stable until decode accepts it.
// On acceptance the next PC is formed from the redirect information that
// decode hands back.
//
// Only one access is outstanding at a time. No speculative fetch is done:
// the next request is issued only after the current instruction is accepted.
// A redirect therefore costs no extra cycle.
//
// Ports
//   clk         in   1   clock; every state update happens on posedge
//   rst         in   1   synchronous, active-high reset
//   id_ready    in   1   decode accepts the held instruction this cycle
//   halt        in   1   held instruction is HALT; sampled only while holding
//   jalr        in   1   register-indirect redirect: register + fimm
//   brj         in   1   PC-relative redirect: pc_plus2 + fimm
//   fimm        in  16   sign-extended immediate from decode
//   register    in  16   Rs value from decode
//   imem_rdata  in  16   memory read data, valid together with imem_done
//   imem_stall  in   1   memory is not accepting the request this cycle
//   imem_done   in   1   read data is returned this cycle
//   imem_err    in   1   memory reports a fault
//   imem_addr   out 16   fetch address (always equal to pc)
//   imem_rd     out  1   read request
//   instr       out 16   held instruction (NOP_INSTR when none is held)
//   instr_valid out  1   instr is valid
//   pc          out 16   address of the held instruction
//   pc_plus2    out 16   pc + 2, used for link writes
//   halted      out  1   sticky; fetch stopped by HALT
//   error       out  1   sticky; fetch fault
// -----------------------------------------------------------------------------
module fetch_stallmem #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MAX_WAIT  = 15,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ready,
  input  logic        halt,
  input  logic        jalr,
  input  logic        brj,
  input  logic [15:0] fimm,
  input  logic [15:0] register,
  input  logic [15:0] imem_rdata,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_HALTED = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // Value of the wait counter on the last allowed WAIT cycle: the counter
  // starts at 0 on the first WAIT cycle, so reaching this value without a
  // response means MAX_WAIT cycles have passed with no data.
  localparam logic [3:0] LP_LAST_WAIT = 4'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [3:0]  r_wait_cnt;

  logic [15:0] w_pc_plus2;
  logic [15:0] w_target;
  logic        w_latch_instr;
  logic        w_load_pc;

  // All adds are 16 bits wide and wrap naturally (0xFFFE + 2 = 0x0000).
  assign w_pc_plus2 = r_pc + 16'd2;
  // jalr takes priority over brj when decode raises both.
  assign w_target   = jalr ? (register + fimm)
                    : brj  ? (w_pc_plus2 + fimm)
                    :        w_pc_plus2;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_latch_instr = 1'b0;
    w_load_pc     = 1'b0;

    unique case (r_state)
      S_REQ: begin
        if (imem_err) begin
          w_next_state = S_ERR;
        end else if (imem_stall) begin
          w_next_state = S_REQ;
        end else if (imem_done) begin
          w_latch_instr = 1'b1;
          w_next_state  = S_HOLD;
        end else begin
          w_next_state = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_err) begin
          w_next_state = S_ERR;
        end else if (imem_done) begin
          w_latch_instr = 1'b1;
          w_next_state  = S_HOLD;
        end else if (r_wait_cnt == LP_LAST_WAIT) begin
          w_next_state = S_ERR;
        end
      end

      S_HOLD: begin
        if (id_ready) begin
          if (halt) begin
            w_next_state = S_HALTED;
          end else if (w_target[0]) begin
            // A misaligned target is a fault; the PC keeps pointing at the
            // instruction that produced it.
            w_next_state = S_ERR;
          end else begin
            w_load_pc    = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end

      S_HALTED: w_next_state = S_HALTED;
      S_ERR:    w_next_state = S_ERR;
      default:  w_next_state = S_ERR;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;

      if (w_latch_instr) begin
        r_instr <= imem_rdata;
      end

      if (w_load_pc) begin
        r_pc <= w_target;
      end

      // The counter restarts on every request so each WAIT phase gets the
      // full budget.
      if (r_state == S_REQ) begin
        r_wait_cnt <= 4'd0;
      end else if (r_state == S_WAIT && !imem_done) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  // Every output is a decode of flops only, with no combinational path from
  // any input, so decode and memory see clean signals for the whole cycle.
  assign imem_addr   = r_pc;
  assign imem_rd     = (r_state == S_REQ);
  assign instr_valid = (r_state == S_HOLD);
  assign instr       = instr_valid ? r_instr : NOP_INSTR;
  assign pc          = r_pc;
  assign pc_plus2    = w_pc_plus2;
  assign halted      = (r_state == S_HALTED);
  assign error       = (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_stallmem.sv
// -----------------------------------------------------------------------------
// tb_fetch_stallmem
//
// Bench for fetch_stallmem. A behavioural model of the fetch rules runs in
// step with the DUT and every cycle's outputs are compared against it.
// Directed sequences cover reset, stalls, hold, timeout, halt and reset
// during a wait. A table of redirect cases covers next-PC selection, wrap
// and misalignment. A randomized phase then exercises everything together.
// -----------------------------------------------------------------------------
module tb_fetch_stallmem;

  localparam logic [15:0] NOP    = 16'h0800;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          MAXW   = 15;

  // Model phases: waiting to issue, waiting for data, holding an
  // instruction, stopped by halt, stopped by a fault.
  localparam int MD_ASK   = 0;
  localparam int MD_PEND  = 1;
  localparam int MD_GOT   = 2;
  localparam int MD_STOP  = 3;
  localparam int MD_FAULT = 4;

  logic        clk = 1'b0;
  logic        rst, id_ready, halt, jalr, brj;
  logic [15:0] fimm, rs_val, imem_rdata;
  logic        imem_stall, imem_done, imem_err;
  logic [15:0] imem_addr, instr, pc, pc_plus2;
  logic        imem_rd, instr_valid, halted, error;

  always #5 clk = ~clk;

  fetch_stallmem dut (
    .clk        (clk),
    .rst        (rst),
    .id_ready   (id_ready),
    .halt       (halt),
    .jalr       (jalr),
    .brj        (brj),
    .fimm       (fimm),
    .register   (rs_val),
    .imem_rdata (imem_rdata),
    .imem_stall (imem_stall),
    .imem_done  (imem_done),
    .imem_err   (imem_err),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .halted     (halted),
    .error      (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  int          m_waited;
  bit          m_known = 1'b0;

  typedef struct {
    logic [15:0] base;
    logic        jalr_v;
    logic        brj_v;
    logic [15:0] fimm_v;
    logic [15:0] rs_v;
    logic [15:0] exp_addr;
    logic        exp_err;
  } redir_t;

  redir_t tbl [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_dut();
    logic [127:0] v;
    v = {imem_rd, imem_addr, instr_valid, instr, pc, pc_plus2, halted, error};
    return v;
  endfunction

  function automatic logic [127:0] pack_model();
    logic [127:0] v;
    logic [15:0]  exp_instr;
    exp_instr = (m_mode == MD_GOT) ? m_instr : NOP;
    v = {(m_mode == MD_ASK), m_pc, (m_mode == MD_GOT), exp_instr,
         m_pc, m_pc + 16'd2, (m_mode == MD_STOP), (m_mode == MD_FAULT)};
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic [15:0] tgt;
    if (rst) begin
      m_mode   = MD_ASK;
      m_pc     = RST_PC;
      m_instr  = NOP;
      m_waited = 0;
      return;
    end
    case (m_mode)
      MD_ASK: begin
        if (imem_err)        m_mode = MD_FAULT;
        else if (imem_stall) m_mode = MD_ASK;
        else if (imem_done) begin
          m_instr = imem_rdata;
          m_mode  = MD_GOT;
        end else begin
          m_waited = 0;
          m_mode   = MD_PEND;
        end
      end
      MD_PEND: begin
        if (imem_err) m_mode = MD_FAULT;
        else if (imem_done) begin
          m_instr = imem_rdata;
          m_mode  = MD_GOT;
        end else begin
          m_waited++;
          if (m_waited >= MAXW) m_mode = MD_FAULT;
        end
      end
      MD_GOT: begin
        if (id_ready) begin
          if (halt) m_mode = MD_STOP;
          else begin
            if (jalr)     tgt = rs_val + fimm;
            else if (brj) tgt = m_pc + 16'd2 + fimm;
            else          tgt = m_pc + 16'd2;
            if (tgt % 2 != 0) m_mode = MD_FAULT;
            else begin
              m_pc   = tgt;
              m_mode = MD_ASK;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clock: compare the current outputs with the model, advance both.
  task automatic step();
    if (m_known) check("cycle_model", pack_dut(), pack_model());
    model_update();
    m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rst        = 1'b0;
    id_ready   = 1'b0;
    halt       = 1'b0;
    jalr       = 1'b0;
    brj        = 1'b0;
    fimm       = 16'h0000;
    rs_val     = 16'h0000;
    imem_rdata = 16'h0000;
    imem_stall = 1'b0;
    imem_done  = 1'b0;
    imem_err   = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runaway guard: the run is only a few tens of microseconds long.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          rd_cnt;
  int          first_valid;
  bit          stable;

  initial begin
    tbl[0] = '{16'h0010, 1'b0, 1'b1, 16'hFFFA, 16'h0000, 16'h000C, 1'b0};
    tbl[1] = '{16'h0020, 1'b1, 1'b0, 16'h0004, 16'h0100, 16'h0104, 1'b0};
    tbl[2] = '{16'h0030, 1'b1, 1'b1, 16'h0004, 16'h0100, 16'h0104, 1'b0};
    tbl[3] = '{16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[4] = '{16'h0040, 1'b0, 1'b0, 16'h1234, 16'h4444, 16'h0042, 1'b0};
    tbl[5] = '{16'h0050, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0062, 1'b0};
    tbl[6] = '{16'h0060, 1'b1, 1'b0, 16'h0004, 16'h00FD, 16'h0060, 1'b1};
    tbl[7] = '{16'hFFFC, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b0};

    // Reset state and a same-cycle memory response.
    do_reset();
    check("rst_pc",     pc,          RST_PC);
    check("rst_instr",  instr,       NOP);
    check("rst_valid",  instr_valid, 1'b0);
    check("rst_flags",  {halted, error}, 2'b00);
    check("first_req",  imem_rd,     1'b1);
    imem_done  = 1'b1;
    imem_rdata = 16'h4000;
    step();
    clr_in();
    check("t1_valid", instr_valid, 1'b1);
    check("t1_instr", instr,       16'h4000);
    check("t1_pc",    pc,          16'h0000);

    // Three stalled request cycles, one more request cycle, then data on
    // the second wait cycle.
    do_reset();
    rd_cnt      = 0;
    first_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      if (imem_rd) rd_cnt++;
      if (instr_valid && first_valid == 0) first_valid = c;
      clr_in();
      if (c <= 3) imem_stall = 1'b1;
      if (c == 6) begin
        imem_done  = 1'b1;
        imem_rdata = 16'hBEEF;
      end
      step();
    end
    check("t2_rd_cycles", rd_cnt,      4);
    check("t2_valid_cyc", first_valid, 7);
    check("t2_instr",     instr,       16'hBEEF);

    // Decode stalls for five cycles: nothing may move, no new request.
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      clr_in();
      imem_done  = 1'b1;
      imem_rdata = 16'h7777;
      step();
      if (instr !== 16'hBEEF || pc !== 16'h0000 || imem_rd !== 1'b0 || instr_valid !== 1'b1)
        stable = 1'b0;
    end
    check("t4_hold_stable", stable, 1'b1);
    clr_in();
    id_ready = 1'b1;
    step();
    clr_in();
    check("t4_seq_addr", {imem_rd, imem_addr}, {1'b1, 16'h0002});

    // Redirect table: move the PC to the base, fetch, then accept with the
    // record's redirect signals.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      imem_done = 1'b1;
      step();
      clr_in();
      id_ready = 1'b1;
      jalr     = 1'b1;
      rs_val   = tbl[i].base;
      step();
      clr_in();
      imem_done  = 1'b1;
      imem_rdata = 16'h1111;
      step();
      clr_in();
      check($sformatf("tbl%0d_base", i), {instr_valid, pc}, {1'b1, tbl[i].base});
      id_ready = 1'b1;
      jalr     = tbl[i].jalr_v;
      brj      = tbl[i].brj_v;
      fimm     = tbl[i].fimm_v;
      rs_val   = tbl[i].rs_v;
      step();
      clr_in();
      if (tbl[i].exp_err)
        check($sformatf("tbl%0d_err", i), {error, pc, imem_rd}, {1'b1, tbl[i].base, 1'b0});
      else
        check($sformatf("tbl%0d_addr", i), {error, imem_rd, imem_addr}, {1'b0, 1'b1, tbl[i].exp_addr});
    end

    // Timeout: fifteen wait cycles with no data raise a sticky error.
    do_reset();
    step();
    for (int c = 0; c < MAXW - 1; c++) step();
    check("t5_not_yet", error, 1'b0);
    step();
    check("t5_timeout", error, 1'b1);
    imem_done = 1'b1;
    step();
    step();
    clr_in();
    check("t5_sticky", {error, instr_valid, imem_rd}, {1'b1, 1'b0, 1'b0});

    // HALT on acceptance stops fetch for good.
    do_reset();
    imem_done = 1'b1;
    step();
    clr_in();
    id_ready = 1'b1;
    halt     = 1'b1;
    step();
    clr_in();
    check("t6_halted", {halted, instr_valid, error}, {1'b1, 1'b0, 1'b0});
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      imem_done = 1'b1;
      id_ready  = 1'b1;
      step();
      if (imem_rd) rd_cnt++;
    end
    clr_in();
    check("t6_no_rd", {rd_cnt, halted}, {32'd0, 1'b1});

    // Reset in the middle of a wait abandons the access.
    do_reset();
    imem_done = 1'b1;
    step();
    clr_in();
    id_ready = 1'b1;
    step();
    clr_in();
    step();
    check("t6_in_wait", {pc, imem_rd}, {16'h0002, 1'b0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_wait", {pc, imem_rd, instr_valid}, {RST_PC, 1'b1, 1'b0});

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0) ||
            ((m_mode == MD_STOP || m_mode == MD_FAULT) && $urandom_range(0, 7) == 0);
      id_ready   = $urandom_range(0, 1) == 1;
      halt       = $urandom_range(0, 19) == 0;
      jalr       = $urandom_range(0, 5) == 0;
      brj        = $urandom_range(0, 3) == 0;
      fimm       = 16'($urandom);
      rs_val     = 16'($urandom);
      if ($urandom_range(0, 15) != 0) fimm[0] = 1'b0;
      if ($urandom_range(0, 15) != 0) rs_val[0] = 1'b0;
      imem_stall = $urandom_range(0, 3) == 0;
      imem_done  = $urandom_range(0, 2) == 0;
      imem_err   = $urandom_range(0, 49) == 0;
      imem_rdata = 16'($urandom);
      step();
    end
    clr_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
